// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and saturation helper for the CNN datapath stages.
package cnn_pkg;

   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   localparam int ACC_W  = 36;

   localparam int IMG = 4;
   localparam int K   = 3;
   localparam int OUT = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_STORE = 2'd2,
      ST_DONE  = 2'd3
   } conv_state_e;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DATA_W-1)));

   function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX)
         return SAT_MAX[DATA_W-1:0];
      else if (v < SAT_MIN)
         return SAT_MIN[DATA_W-1:0];
      else
         return v[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered signed multiply-accumulate; clear has priority over enable.
module mac_unit
   import cnn_pkg::*;
#(
   parameter int OP_W  = DATA_W,
   parameter int SUM_W = ACC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [OP_W-1:0]  a,
   input  logic signed [OP_W-1:0]  b,
   output logic signed [SUM_W-1:0] acc
);

   logic signed [2*OP_W-1:0] prod;
   logic signed [SUM_W-1:0]  acc_d;
   logic signed [SUM_W-1:0]  acc_q;

   always_comb begin
      prod  = a * b;
      acc_d = acc_q;
      if (clr)
         acc_d = '0;
      else if (en)
         acc_d = acc_q + SUM_W'(prod);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/conv3x3_relu_stage.sv
// Sequential 3x3 valid convolution + optional ReLU over a 4x4 Q8.8 image, one MAC per cycle.
//   state    | meaning
//   IDLE     | waiting for start; captures image and kernel on accept
//   MAC      | accumulates one kernel tap per cycle for the current position
//   STORE    | rescales, saturates, applies ReLU and writes one output
//   DONE     | one-cycle done pulse, then back to IDLE
module conv3x3_relu_stage
   import cnn_pkg::*;
#(
   parameter int DATA_W  = cnn_pkg::DATA_W,
   parameter int FRAC_W  = cnn_pkg::FRAC_W,
   parameter int ACC_W   = cnn_pkg::ACC_W,
   parameter int RELU_EN = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] input_feature  [IMG][IMG],
   input  logic signed [DATA_W-1:0] kernel_weights [K][K],
   output logic                     busy,
   output logic                     done,
   output logic signed [DATA_W-1:0] feature_map [OUT*OUT-1:0],
   output logic [OUT*OUT-1:0]       relu_mask
);

   conv_state_e state_q, state_d;
   logic [3:0]  tap_q, tap_d;
   logic [1:0]  pos_q, pos_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [OUT*OUT-1:0] mask_q, mask_d;

   logic signed [DATA_W-1:0] img_q [IMG][IMG];
   logic signed [DATA_W-1:0] img_d [IMG][IMG];
   logic signed [DATA_W-1:0] ker_q [K][K];
   logic signed [DATA_W-1:0] ker_d [K][K];
   logic signed [DATA_W-1:0] fm_q  [OUT*OUT-1:0];
   logic signed [DATA_W-1:0] fm_d  [OUT*OUT-1:0];

   logic                     mac_clr, mac_en;
   logic signed [DATA_W-1:0] mac_a, mac_b;
   logic signed [ACC_W-1:0]  acc, scaled;
   logic signed [DATA_W-1:0] sat_val;
   logic                     scaled_pos;
   logic [1:0]               ki, kj, row, col;

   // tap = 3*ki + kj; window origin is (pos>>1, pos&1)
   always_comb begin
      ki = 2'd0;
      if (tap_q >= 4'd6)
         ki = 2'd2;
      else if (tap_q >= 4'd3)
         ki = 2'd1;
      case (tap_q)
         4'd0, 4'd3, 4'd6: kj = 2'd0;
         4'd1, 4'd4, 4'd7: kj = 2'd1;
         default:          kj = 2'd2;
      endcase
      row   = {1'b0, pos_q[1]} + ki;
      col   = {1'b0, pos_q[0]} + kj;
      mac_a = img_q[row][col];
      mac_b = ker_q[ki][kj];
   end

   mac_unit #(.OP_W(DATA_W), .SUM_W(ACC_W)) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (mac_a),
      .b   (mac_b),
      .acc (acc)
   );

   assign scaled     = acc >>> FRAC_W;
   assign sat_val    = sat_data(scaled);
   assign scaled_pos = !scaled[ACC_W-1] && (scaled != '0);

   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      pos_d   = pos_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      mask_d  = mask_q;
      img_d   = img_q;
      ker_d   = ker_q;
      fm_d    = fm_q;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               img_d   = input_feature;
               ker_d   = kernel_weights;
               mac_clr = 1'b1;
               tap_d   = 4'd0;
               pos_d   = 2'd0;
               busy_d  = 1'b1;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            mac_en = 1'b1;
            if (tap_q == 4'd8)
               state_d = ST_STORE;
            else
               tap_d = tap_q + 4'd1;
         end
         ST_STORE: begin
            fm_d[pos_q]   = (RELU_EN != 0 && !scaled_pos) ? '0 : sat_val;
            mask_d[pos_q] = scaled_pos;
            mac_clr       = 1'b1;
            tap_d         = 4'd0;
            if (pos_q == 2'd3) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               pos_d   = pos_q + 2'd1;
               state_d = ST_MAC;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         tap_q   <= '0;
         pos_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mask_q  <= '0;
         img_q   <= '{default: '0};
         ker_q   <= '{default: '0};
         fm_q    <= '{default: '0};
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         pos_q   <= pos_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mask_q  <= mask_d;
         img_q   <= img_d;
         ker_q   <= ker_d;
         fm_q    <= fm_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign relu_mask   = mask_q;
   assign feature_map = fm_q;

endmodule

// File: tb/tb_conv3x3_relu_stage.sv
// Scoreboard bench: two DUTs (ReLU on / off) share stimulus; a monitor pops expected results on done.
module tb_conv3x3_relu_stage;

   typedef struct packed {
      logic [3:0][15:0] fm;
      logic [3:0]       mask;
   } ex_t;

   logic clk, rst, start;
   logic signed [15:0] in_f [4][4];
   logic signed [15:0] k_w  [3][3];
   logic busy1, done1, busy2, done2;
   logic signed [15:0] fm1 [3:0];
   logic signed [15:0] fm2 [3:0];
   logic [3:0] mask1, mask2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   ex_t q1[$];
   ex_t q2[$];

   conv3x3_relu_stage #(.RELU_EN(1)) dut_relu (
      .clk(clk), .rst(rst), .start(start),
      .input_feature(in_f), .kernel_weights(k_w),
      .busy(busy1), .done(done1), .feature_map(fm1), .relu_mask(mask1)
   );

   conv3x3_relu_stage #(.RELU_EN(0)) dut_lin (
      .clk(clk), .rst(rst), .start(start),
      .input_feature(in_f), .kernel_weights(k_w),
      .busy(busy2), .done(done2), .feature_map(fm2), .relu_mask(mask2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   function automatic ex_t mk(input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] a2, input logic [15:0] a3,
                              input logic [3:0] m);
      ex_t e;
      e.fm[0] = a0;
      e.fm[1] = a1;
      e.fm[2] = a2;
      e.fm[3] = a3;
      e.mask  = m;
      return e;
   endfunction

   function automatic ex_t all4(input logic [15:0] v, input logic [3:0] m);
      return mk(v, v, v, v, m);
   endfunction

   always @(negedge clk) begin
      ex_t e;
      if (done1) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done_relu got=done want=no_done");
         end else begin
            e = q1.pop_front();
            for (int p = 0; p < 4; p++)
               check($sformatf("relu_fm[%0d]", p), fm1[p], e.fm[p]);
            check("relu_mask", {12'd0, mask1}, {12'd0, e.mask});
         end
      end
      if (done2) begin
         if (q2.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done_lin got=done want=no_done");
         end else begin
            e = q2.pop_front();
            for (int p = 0; p < 4; p++)
               check($sformatf("lin_fm[%0d]", p), fm2[p], e.fm[p]);
            check("lin_mask", {12'd0, mask2}, {12'd0, e.mask});
         end
      end
   end

   task automatic set_data(input logic signed [15:0] iv, input logic signed [15:0] kv);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            in_f[i][j] = iv;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            k_w[i][j] = kv;
   endtask

   task automatic accept(output int t0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t0 = cyc;
      check("busy_rise", {15'd0, busy1}, 16'd1);
   endtask

   task automatic wait_done(input int t0, input int want, input string name);
      int n;
      n = 0;
      while (!done1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done1) begin
         total++; bad++;
         $display("FAIL %s_timeout got=no_done want=done", name);
      end else begin
         check({name, "_latency"}, 16'(cyc - t0), 16'(want));
      end
      @(negedge clk);
      check({name, "_busy_fall"}, {15'd0, busy1}, 16'd0);
      check({name, "_done_pulse"}, {15'd0, done1}, 16'd0);
   endtask

   task automatic run(input string name, input ex_t e1, input ex_t e2);
      int t0;
      q1.push_back(e1);
      q2.push_back(e2);
      accept(t0);
      wait_done(t0, 40, name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, d1, d2;
      rst   = 1'b1;
      start = 1'b0;
      set_data(16'sd0, 16'sd0);
      #2 rst = 1'b0;
      #1;
      check("rst_busy", {15'd0, busy1}, 16'd0);
      check("rst_done", {15'd0, done1}, 16'd0);
      check("rst_mask", {12'd0, mask1}, 16'd0);
      check("rst_fm0", fm1[0], 16'd0);
      check("rst_fm3", fm2[3], 16'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // nominal: 256*64*9 >> 8 = 576
      set_data(16'sd256, 16'sd64);
      run("nominal", all4(16'd576, 4'b1111), all4(16'd576, 4'b1111));

      // centre tap 1.0 picks in[r0+1][c0+1]
      set_data(16'sd0, 16'sd0);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            in_f[i][j] = 16'(256 * (4 * i + j));
      k_w[1][1] = 16'sd256;
      run("position", mk(16'd1280, 16'd1536, 16'd2304, 16'd2560, 4'b1111),
                      mk(16'd1280, 16'd1536, 16'd2304, 16'd2560, 4'b1111));

      set_data(16'sd256, -16'sd64);
      run("negative", all4(16'd0, 4'b0000), all4(16'hFDC0, 4'b0000));

      set_data(16'sd1, 16'sd0);
      k_w[1][1] = -16'sd1;
      run("trunc", all4(16'd0, 4'b0000), all4(16'hFFFF, 4'b0000));

      set_data(16'sd32767, 16'sd32767);
      run("sat_pos", all4(16'h7FFF, 4'b1111), all4(16'h7FFF, 4'b1111));

      set_data(16'sd32767, -16'sd32768);
      run("sat_neg", all4(16'd0, 4'b0000), all4(16'h8000, 4'b0000));

      // second start mid-run with new data must be ignored
      set_data(16'sd256, 16'sd64);
      q1.push_back(all4(16'd576, 4'b1111));
      q2.push_back(all4(16'd576, 4'b1111));
      accept(t0);
      @(negedge clk);
      set_data(16'sd32767, 16'sd32767);
      while (cyc < t0 + 4) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(t0, 40, "ignore_start");

      // start held high: accepts at E0 and E42, done at E40 and E82
      set_data(16'sd256, 16'sd64);
      for (int n = 0; n < 2; n++) begin
         q1.push_back(all4(16'd576, 4'b1111));
         q2.push_back(all4(16'd576, 4'b1111));
      end
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 t0 = cyc;
      d1 = -1;
      d2 = -1;
      for (int n = 0; n < 120 && d2 < 0; n++) begin
         @(negedge clk);
         if (done1) begin
            if (d1 < 0) d1 = cyc - t0;
            else        d2 = cyc - t0;
         end
      end
      start = 1'b0;
      check("b2b_first_done", 16'(d1), 16'd40);
      check("b2b_second_done", 16'(d2), 16'd82);
      repeat (3) @(negedge clk);
      check("b2b_idle", {15'd0, busy1}, 16'd0);

      // asynchronous reset between E20 and E21 aborts the run
      set_data(16'sd256, -16'sd64);
      accept(t0);
      while (cyc < t0 + 20) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_busy", {15'd0, busy1}, 16'd0);
      check("abort_done", {15'd0, done1}, 16'd0);
      check("abort_mask", {12'd0, mask1}, 16'd0);
      for (int p = 0; p < 4; p++)
         check($sformatf("abort_fm[%0d]", p), fm1[p], 16'd0);
      check("abort_busy_lin", {15'd0, busy2}, 16'd0);
      @(negedge clk);
      rst = 1'b1;
      set_data(16'sd256, 16'sd64);
      run("after_reset", all4(16'd576, 4'b1111), all4(16'd576, 4'b1111));

      repeat (2) @(negedge clk);
      check("queue_relu_empty", 16'(q1.size()), 16'd0);
      check("queue_lin_empty", 16'(q2.size()), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
